// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter with slave bclk/lrclk timing.
// A one-deep holding register feeds a per-frame active L/R pair that is serialised MSB first.
module i2s_tx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              bclk_i,
  input  logic              lrclk_i,
  input  logic [DATA_W-1:0] audio_l_i,
  input  logic [DATA_W-1:0] audio_r_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              frame_o,
  output logic              underrun_o,
  output logic              tx_o
);

  localparam int             K_W    = $clog2(SLOT_W + 1);
  localparam int             IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [K_W-1:0] K_ZERO = {K_W{1'b0}};
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_MAX  = K_W'(SLOT_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  logic              bclk_meta_r, bclk_sync_r, bclk_hist_r;
  logic              lr_meta_r, lr_sync_r, lr_prev_r;
  logic [1:0]        state_r, state_nxt_s;
  logic [K_W-1:0]    k_r, k_nxt_s;
  logic              hold_full_r, hold_full_nxt_s;
  logic [DATA_W-1:0] hold_l_r, hold_r_r;
  logic [DATA_W-1:0] act_l_r, act_r_r, act_l_nxt_s, act_r_nxt_s;
  logic [DATA_W-1:0] word_s;
  logic              ready_r, frame_r, underrun_r, tx_r, tx_nxt_s;
  logic              bclk_fall_s, slot_start_s, left_start_s, right_start_s;
  logic              xfer_s, load_hold_s;

  // Bit k of a slot: k=0 is the I2S delay bit, then MSB first, zero past the LSB.
  function automatic logic slot_bit(input logic [DATA_W-1:0] word, input logic [K_W-1:0] k);
    logic             b;
    logic [IDX_W-1:0] idx;
    b   = 1'b0;
    idx = {IDX_W{1'b0}};
    if ((k != K_ZERO) && (int'(k) <= DATA_W)) begin
      idx = IDX_W'(DATA_W - int'(k));
      b   = word[idx];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  assign bclk_fall_s   = bclk_hist_r & ~bclk_sync_r;
  assign slot_start_s  = bclk_fall_s & (lr_sync_r ^ lr_prev_r);
  assign left_start_s  = slot_start_s & ~lr_sync_r;
  assign right_start_s = slot_start_s & lr_sync_r;
  assign xfer_s        = valid_i & ~hold_full_r;
  assign load_hold_s   = xfer_s & ~left_start_s;

  assign ready_o    = ready_r;
  assign frame_o    = frame_r;
  assign underrun_o = underrun_r;
  assign tx_o       = tx_r;

  // Synchronise bclk/lrclk into clk_i; lrclk is only sampled at bclk falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bclk_meta_r <= 1'b0;
      bclk_sync_r <= 1'b0;
      bclk_hist_r <= 1'b0;
      lr_meta_r   <= 1'b0;
      lr_sync_r   <= 1'b0;
      lr_prev_r   <= 1'b0;
    end else begin
      bclk_meta_r <= bclk_i;
      bclk_sync_r <= bclk_meta_r;
      bclk_hist_r <= bclk_sync_r;
      lr_meta_r   <= lrclk_i;
      lr_sync_r   <= lr_meta_r;
      if (bclk_fall_s) begin
        lr_prev_r <= lr_sync_r;
      end
    end
  end

  // Slot FSM: right starts are ignored until the first left start.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (left_start_s)  state_nxt_s = ST_LEFT;  else state_nxt_s = ST_IDLE;
      ST_LEFT:  if (right_start_s) state_nxt_s = ST_RIGHT; else state_nxt_s = ST_LEFT;
      ST_RIGHT: if (left_start_s)  state_nxt_s = ST_LEFT;  else state_nxt_s = ST_RIGHT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Bit counter and serial data; the delay bit goes out on the slot-start fall itself.
  always_comb begin
    k_nxt_s  = k_r;
    tx_nxt_s = tx_r;
    word_s   = (state_r == ST_RIGHT) ? act_r_r : act_l_r;
    if (slot_start_s) begin
      k_nxt_s = K_ONE;
    end else if (bclk_fall_s && (k_r != K_MAX)) begin
      k_nxt_s = k_r + K_ONE;
    end else begin
      k_nxt_s = k_r;
    end
    if (!bclk_fall_s) begin
      tx_nxt_s = tx_r;
    end else if (slot_start_s || (state_r == ST_IDLE)) begin
      tx_nxt_s = 1'b0;
    end else begin
      tx_nxt_s = slot_bit(word_s, k_r);
    end
  end

  // Holding register handshake and frame-aligned load of the active pair.
  always_comb begin
    hold_full_nxt_s = hold_full_r;
    act_l_nxt_s     = act_l_r;
    act_r_nxt_s     = act_r_r;
    if (left_start_s) begin
      hold_full_nxt_s = 1'b0;
      if (hold_full_r) begin
        act_l_nxt_s = hold_l_r;
        act_r_nxt_s = hold_r_r;
      end else if (valid_i) begin
        act_l_nxt_s = audio_l_i;
        act_r_nxt_s = audio_r_i;
      end else begin
        act_l_nxt_s = {DATA_W{1'b0}};
        act_r_nxt_s = {DATA_W{1'b0}};
      end
    end else if (xfer_s) begin
      hold_full_nxt_s = 1'b1;
    end else begin
      hold_full_nxt_s = hold_full_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      k_r         <= K_ZERO;
      hold_full_r <= 1'b0;
      hold_l_r    <= {DATA_W{1'b0}};
      hold_r_r    <= {DATA_W{1'b0}};
      act_l_r     <= {DATA_W{1'b0}};
      act_r_r     <= {DATA_W{1'b0}};
      ready_r     <= 1'b1;
      frame_r     <= 1'b0;
      underrun_r  <= 1'b0;
      tx_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      if (load_hold_s) begin
        hold_l_r <= audio_l_i;
        hold_r_r <= audio_r_i;
      end
      act_l_r     <= act_l_nxt_s;
      act_r_r     <= act_r_nxt_s;
      ready_r     <= ~hold_full_nxt_s;
      frame_r     <= left_start_s;
      underrun_r  <= left_start_s & ~hold_full_r & ~valid_i;
      tx_r        <= tx_nxt_s;
    end
  end

endmodule
